// File: rtl/vga_frame_reader_if.sv
// VRAM read port and VGA output bundle between the frame reader and its neighbours.
`timescale 1ns/1ps
interface vga_frame_reader_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] pixel_read_address_o;
    logic [DATA_WIDTH-1:0] pixel_data_i;
    logic [3:0]            vga_r_o;
    logic [3:0]            vga_g_o;
    logic [3:0]            vga_b_o;
    logic                  hsync_o;
    logic                  vsync_o;
    logic                  video_on_o;
    logic                  frame_start_o;

    modport master (
        output pixel_read_address_o,
        input  pixel_data_i,
        output vga_r_o,
        output vga_g_o,
        output vga_b_o,
        output hsync_o,
        output vsync_o,
        output video_on_o,
        output frame_start_o
    );

    modport slave (
        input  pixel_read_address_o,
        output pixel_data_i,
        input  vga_r_o,
        input  vga_g_o,
        input  vga_b_o,
        input  hsync_o,
        input  vsync_o,
        input  video_on_o,
        input  frame_start_o
    );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a 320x240 VRAM frame, doubled in both axes,
// with RGB444 and syncs registered one pixel period after the address is issued.
`timescale 1ns/1ps
module vga_frame_reader #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 4,
    parameter int FRAME_W    = 320,
    parameter int FRAME_H    = 240
) (
    input  logic               clk_i,
    input  logic               reset_i,
    vga_frame_reader_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_VISIBLE    = 10'(2 * FRAME_W);
    localparam logic [9:0] H_SYNC_FIRST = 10'd656;
    localparam logic [9:0] H_SYNC_LAST  = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'(2 * FRAME_H);
    localparam logic [9:0] V_SYNC_FIRST = 10'd490;
    localparam logic [9:0] V_SYNC_LAST  = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(FRAME_W);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);

    logic [DIV_W-1:0]      div_reg;
    logic                  tick;
    logic [9:0]            h_cnt_reg, h_cnt_next;
    logic [9:0]            v_cnt_reg, v_cnt_next;
    logic                  h_wrap;
    logic                  frame_wrap;
    logic                  visible_cur;
    logic                  visible_next;
    logic [ADDR_WIDTH-1:0] line_base_reg, line_base_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] rgb_reg;
    logic                  hsync_reg;
    logic                  vsync_reg;
    logic                  video_on_reg;
    logic                  frame_start_reg;

    assign tick = (div_reg == DIV_LAST);

    always_comb begin
        h_wrap         = (h_cnt_reg == H_LAST);
        frame_wrap     = h_wrap && (v_cnt_reg == V_LAST);
        h_cnt_next     = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
        v_cnt_next     = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
        end
        visible_cur    = (h_cnt_reg < H_VISIBLE) && (v_cnt_reg < V_VISIBLE);
        visible_next   = (h_cnt_next < H_VISIBLE) && (v_cnt_next < V_VISIBLE);

        // Stored row base advances only on even display lines, giving line doubling.
        line_base_next = line_base_reg;
        if (h_wrap) begin
            if (v_cnt_next == 10'd0) begin
                line_base_next = '0;
            end else if ((v_cnt_next < V_VISIBLE) && !v_cnt_next[0]) begin
                line_base_next = line_base_reg + LINE_STRIDE;
            end
        end

        // Column doubling: step the address only when entering an even column.
        addr_next = addr_reg;
        if (visible_next) begin
            if (h_cnt_next == 10'd0) begin
                addr_next = line_base_next;
            end else if (!h_cnt_next[0]) begin
                addr_next = addr_reg + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            div_reg       <= '0;
            h_cnt_reg     <= '0;
            v_cnt_reg     <= '0;
            line_base_reg <= '0;
            addr_reg      <= '0;
        end else begin
            div_reg <= tick ? '0 : div_reg + DIV_ONE;
            if (tick) begin
                h_cnt_reg     <= h_cnt_next;
                v_cnt_reg     <= v_cnt_next;
                line_base_reg <= line_base_next;
                addr_reg      <= addr_next;
            end
        end
    end

    // Output stage describes the position being left; VRAM data for it settled CLK_DIV-1 cycles ago.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rgb_reg         <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            video_on_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= tick && frame_wrap;
            if (tick) begin
                rgb_reg      <= visible_cur ? bus.pixel_data_i : '0;
                hsync_reg    <= !((h_cnt_reg >= H_SYNC_FIRST) && (h_cnt_reg <= H_SYNC_LAST));
                vsync_reg    <= !((v_cnt_reg >= V_SYNC_FIRST) && (v_cnt_reg <= V_SYNC_LAST));
                video_on_reg <= visible_cur;
            end
        end
    end

    logic [3:0] chan [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = rgb_reg[DATA_WIDTH-1-4*gi -: 4];
        end
    endgenerate

    assign bus.pixel_read_address_o = addr_reg;
    assign bus.vga_r_o              = chan[0];
    assign bus.vga_g_o              = chan[1];
    assign bus.vga_b_o              = chan[2];
    assign bus.hsync_o              = hsync_reg;
    assign bus.vsync_o              = vsync_reg;
    assign bus.video_on_o           = video_on_reg;
    assign bus.frame_start_o        = frame_start_reg;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: startup, line/column doubling, full-frame timing, data mapping, mid-line reset.
`timescale 1ns/1ps
module tb_vga_frame_reader;
    localparam int CLK_DIV   = 4;
    localparam int FW        = 320;
    localparam int H_TOT     = 800;
    localparam int FRAME_PIX = 800 * 525;

    logic clk = 1'b0;
    logic reset_i;
    bit   const_mode;

    int n_assert = 0;
    int n_fail   = 0;

    int cyc;
    int exp_addr;
    int addr_err, rgb_err, hs_err, vs_err, vo_err;
    int hs_low_line, vo_line, bad_hs_lines, video_lines, bad_vo_lines, vs_low_px;
    int fs_pulses, fs_pos_err, fs_miss;
    int last_hfall, hfalls, period_err;
    logic prev_hs;

    vga_frame_reader_if #(.ADDR_WIDTH(17), .DATA_WIDTH(12)) vif ();

    vga_frame_reader #(
        .ADDR_WIDTH(17), .DATA_WIDTH(12), .CLK_DIV(CLK_DIV), .FRAME_W(FW), .FRAME_H(240)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (vif)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] data_of(input int a);
        return 12'((a * 37) ^ 32'h5A3);
    endfunction

    // Synchronous VRAM: data follows the address by one clock.
    always @(posedge clk)
        vif.pixel_data_i <= const_mode ? 12'hA5C : data_of(int'(vif.pixel_read_address_o));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-20s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic restart_stats();
        cyc = 0; exp_addr = 0;
        addr_err = 0; rgb_err = 0; hs_err = 0; vs_err = 0; vo_err = 0;
        hs_low_line = 0; vo_line = 0; bad_hs_lines = 0; video_lines = 0; bad_vo_lines = 0; vs_low_px = 0;
        fs_pulses = 0; fs_pos_err = 0; fs_miss = 0;
        last_hfall = -1; hfalls = 0; period_err = 0; prev_hs = 1'b1;
    endtask

    task automatic pixel_check();
        int m, p, q, h, v, hp, vp, prev_addr;
        bit vis_q;
        logic [11:0] exp_data;
        m = cyc / CLK_DIV;
        p = m % FRAME_PIX;
        q = (m - 1) % FRAME_PIX;
        h = p % H_TOT;  v = p / H_TOT;
        hp = q % H_TOT; vp = q / H_TOT;
        prev_addr = exp_addr;
        if (h < 640 && v < 480) exp_addr = (v / 2) * FW + h / 2;
        if (vif.pixel_read_address_o !== 17'(exp_addr)) addr_err++;
        vis_q = (hp < 640) && (vp < 480);
        exp_data = vis_q ? (const_mode ? 12'hA5C : data_of(prev_addr)) : 12'h000;
        if ({vif.vga_r_o, vif.vga_g_o, vif.vga_b_o} !== exp_data) rgb_err++;
        if (vif.hsync_o !== !(hp >= 656 && hp <= 751)) hs_err++;
        if (vif.vsync_o !== !(vp == 490 || vp == 491)) vs_err++;
        if (vif.video_on_o !== vis_q) vo_err++;
        if (p == 0 && vif.frame_start_o !== 1'b1) fs_miss++;
        if (vif.hsync_o === 1'b0) hs_low_line++;
        if (vif.video_on_o === 1'b1) vo_line++;
        if (vif.vsync_o === 1'b0) vs_low_px++;
        if (hp == H_TOT - 1) begin
            if (hs_low_line != 96) bad_hs_lines++;
            if (vo_line == 640) video_lines++;
            else if (vo_line != 0) bad_vo_lines++;
            hs_low_line = 0;
            vo_line = 0;
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
        if (vif.frame_start_o === 1'b1) begin
            fs_pulses++;
            if (!((cyc % CLK_DIV == 0) && ((cyc / CLK_DIV) % FRAME_PIX == 0))) fs_pos_err++;
        end
        if (prev_hs === 1'b1 && vif.hsync_o === 1'b0) begin
            if (last_hfall >= 0 && (cyc - last_hfall) != H_TOT * CLK_DIV) period_err++;
            last_hfall = cyc;
            hfalls++;
        end
        prev_hs = vif.hsync_o;
        if (cyc % CLK_DIV == 0) pixel_check();
    endtask

    task automatic run_to(input int m_target);
        while (cyc < m_target * CLK_DIV) clk1();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_addr"}, 32'(vif.pixel_read_address_o), 0);
        check({pfx, "_rgb"}, 32'({vif.vga_r_o, vif.vga_g_o, vif.vga_b_o}), 0);
        check({pfx, "_hsync"}, 32'(vif.hsync_o), 1);
        check({pfx, "_vsync"}, 32'(vif.vsync_o), 1);
        check({pfx, "_video_on"}, 32'(vif.video_on_o), 0);
        check({pfx, "_frame_start"}, 32'(vif.frame_start_o), 0);
    endtask

    initial begin
        reset_i = 1'b0;
        const_mode = 1'b0;
        restart_stats();
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        @(negedge clk);
        reset_i = 1'b1;
        restart_stats();
        repeat (3) clk1();
        check("pre_tick_video_on", 32'(vif.video_on_o), 0);
        clk1();
        check("tick4_video_on", 32'(vif.video_on_o), 1);
        check("tick4_addr", 32'(vif.pixel_read_address_o), 0);
        check("tick4_rgb", 32'({vif.vga_r_o, vif.vga_g_o, vif.vga_b_o}), 32'(data_of(0)));
        run_to(2);
        check("h2_addr", 32'(vif.pixel_read_address_o), 1);
        run_to(3);
        check("h3_addr", 32'(vif.pixel_read_address_o), 1);
        run_to(4);
        check("h4_addr", 32'(vif.pixel_read_address_o), 2);
        check("h3_rgb", 32'({vif.vga_r_o, vif.vga_g_o, vif.vga_b_o}), 32'(data_of(1)));
        run_to(H_TOT);
        check("v1_addr", 32'(vif.pixel_read_address_o), 0);
        run_to(2 * H_TOT);
        check("v2_addr", 32'(vif.pixel_read_address_o), 320);
        run_to(479 * H_TOT + 639);
        check("last_vis_addr", 32'(vif.pixel_read_address_o), 76799);
        run_to(479 * H_TOT + 640);
        check("hblank_hold_addr", 32'(vif.pixel_read_address_o), 76799);
        run_to(480 * H_TOT);
        check("vblank_hold_addr", 32'(vif.pixel_read_address_o), 76799);
        run_to(FRAME_PIX);
        check("frame2_addr", 32'(vif.pixel_read_address_o), 0);
        check("frame2_fs", 32'(vif.frame_start_o), 1);

        check("frame_addr_err", addr_err, 0);
        check("frame_rgb_err", rgb_err, 0);
        check("frame_hsync_err", hs_err, 0);
        check("frame_vsync_err", vs_err, 0);
        check("frame_video_err", vo_err, 0);
        check("bad_hsync_lines", bad_hs_lines, 0);
        check("hsync_falls", hfalls, 525);
        check("line_period_err", period_err, 0);
        check("vsync_low_pixels", vs_low_px, 1600);
        check("video_lines", video_lines, 480);
        check("bad_video_lines", bad_vo_lines, 0);
        check("fs_pulses", fs_pulses, 1);
        check("fs_misplaced", fs_pos_err, 0);
        check("fs_missed", fs_miss, 0);

        run_to(FRAME_PIX + 100 * H_TOT + 300);
        check("mid_addr", 32'(vif.pixel_read_address_o), 50 * FW + 150);
        check("mid_video_on", 32'(vif.video_on_o), 1);
        reset_i = 1'b0;
        #1;
        check_reset_outputs("midrst");

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        restart_stats();
        repeat (3) clk1();
        check("re_pre_tick_video_on", 32'(vif.video_on_o), 0);
        clk1();
        check("re_tick4_video_on", 32'(vif.video_on_o), 1);
        check("re_tick4_addr", 32'(vif.pixel_read_address_o), 0);
        run_to(2);
        check("re_h2_addr", 32'(vif.pixel_read_address_o), 1);
        const_mode = 1'b1;
        run_to(12);
        check("a5c_r", 32'(vif.vga_r_o), 32'hA);
        check("a5c_g", 32'(vif.vga_g_o), 32'h5);
        check("a5c_b", 32'(vif.vga_b_o), 32'hC);
        run_to(701);
        check("blank_rgb", 32'({vif.vga_r_o, vif.vga_g_o, vif.vga_b_o}), 0);
        check("blank_video_on", 32'(vif.video_on_o), 0);
        check("blank_hsync", 32'(vif.hsync_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream consumer of the camera VRAM.
- Generates 640x480@60 VGA timing from a divided pixel tick and drives the VRAM read address.
- Scales the stored 320x240 frame 2x in both axes: each stored pixel is repeated on two columns and on two lines.
- Captures the 12-bit VRAM read data and drives registered RGB444 plus sync signals aligned with it.

Parameters:
ADDR_WIDTH, 17, VRAM address width; must satisfy 2^ADDR_WIDTH >= FRAME_W*FRAME_H.
DATA_WIDTH, 12, VRAM word width: R=[11:8], G=[7:4], B=[3:0].
CLK_DIV, 4, clk_i cycles per VGA pixel; must be >= 2.
FRAME_W, 320, stored frame width in pixels.
FRAME_H, 240, stored frame height in lines.

Ports:
clk_i  in  1  system clock; also the VRAM read clock.
reset_i  in  1  asynchronous, active-low reset.
pixel_read_address_o  out  ADDR_WIDTH  VRAM read address.
pixel_data_i  in  DATA_WIDTH  VRAM read data; valid 1 clk_i after the address.
vga_r_o  out  4  red.
vga_g_o  out  4  green.
vga_b_o  out  4  blue.
hsync_o  out  1  horizontal sync, active low.
vsync_o  out  1  vertical sync, active low.
video_on_o  out  1  high while RGB is in the visible area.
frame_start_o  out  1  one-clk_i pulse at the start of each frame.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - Outputs: address=0, RGB=0, hsync_o=1, vsync_o=1, video_on_o=0, frame_start_o=0.
  - Internal: tick divider=0, h_cnt=0, v_cnt=0.
  - Reset may assert mid-frame; all state returns to these values immediately.
- Tick divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick is high for one clk_i when the divider equals CLK_DIV-1.
  - The first tick after reset release occurs on the CLK_DIV-th rising edge.
- Counters, advancing on tick only:
  - h_cnt runs 0..799 and wraps to 0.
  - When h_cnt wraps, v_cnt increments, running 0..524 and wrapping to 0.
- Visible area: h<640 and v<480.
- Sync timing:
  - hsync active (low) for h in 656..751.
  - vsync active (low) for v in 490..491.
- Address, updated on tick for the counter values being entered (h',v'):
  - Visible: address = (v'>>1)*FRAME_W + (h'>>1).
  - Otherwise: address holds its value.
  - Address range is 0..76799. Each address is issued for two consecutive columns, and each address row repeats on two consecutive lines.
  - Implement with incremental counters/line-base register; no multiplier.
- Read timing: the RAM returns data 1 clk_i after the address changes; since CLK_DIV>=2, the data is stable before the next tick.
- Output stage, registered on tick, describing the (h,v) just completed:
  - RGB = pixel_data_i fields if (h,v) was visible, else 0.
  - hsync_o, vsync_o and video_on_o are registered from the same (h,v).
  - Net latency: position (h,v) appears on the outputs one pixel period (CLK_DIV clk_i) after its counters were entered. Syncs and RGB remain mutually aligned.
- frame_start_o: high for exactly one clk_i on the tick where the counters enter (0,0). It does not fire on the first tick after reset.
- No handshake with the VRAM; the read enable is permanently 1 upstream.

Test Plan:
- Reset release, CLK_DIV=4:
  - First tick on the 4th clk_i edge.
  - Address sequence on successive ticks: 0,0,1,1,2,... per two-column repeat.
  - RGB outputs follow one tick behind the address.
- Line doubling: address at (h=0,v=0) equals address at (h=0,v=1), both 0. At (h=0,v=2) the address is 320.
- Last visible pixel (639,479) -> address 76799.
  - Then the address holds through blanking.
  - Address returns to 0 at (0,0) of the next frame.
  - frame_start_o pulses once, on the tick entering (0,0).
- Timing check over one full frame:
  - hsync_o low for 96 pixels per line.
  - vsync_o low for 2 lines per frame.
  - Line period 800*CLK_DIV clk_i; frame period 525 lines.
  - video_on_o high for 640 pixels on each of 480 lines.
- Data mapping: with pixel_data_i=12'hA5C in the visible area -> r=A, g=5, b=C. The same data during blanking -> r=g=b=0.
- Assert reset_i=0 mid-line at (h=300,v=100):
  - Outputs go to reset values immediately.
  - After release, timing restarts from (0,0) with address 0.
